// File: rtl/softmax_exp_sched.sv
// Softmax exp sequencer: loads a vector, time-shares one combinational exp unit,
// buffers the results with their Q16 sum, then streams them out.
module softmax_exp_sched #(
    parameter int N     = 32,
    parameter int IDX_W = $clog2(N),
    parameter int SUM_W = 32 + $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16:0]      in_data,
    output logic [16:0]      exp_x,
    input  logic [20:0]      exp_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [20:0]      out_exp,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [SUM_W-1:0] sum,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_t;

    localparam logic [IDX_W:0]    LEN_MAX = (IDX_W+1)'(N);
    localparam logic [IDX_W:0]    LEN_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
    localparam logic signed [16:0] SAT_HI = 17'sd40960;
    localparam logic signed [16:0] SAT_LO = -17'sd40960;

    state_t            state_q, state_d;
    logic [IDX_W:0]    len_q, len_d;
    logic [IDX_W:0]    ld_cnt_q, ld_cnt_d;
    logic [16:0]       x_q, x_d;
    logic              v_q, v_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [20:0]       mem_q [N];

    logic [IDX_W:0]    len_m1;
    logic              in_hs;
    logic              out_hs;
    logic              last_beat;
    logic              cfg_ok;
    logic [16:0]       x_sat;
    logic [4:0]        pos;
    logic [31:0]       term;

    assign len_m1    = len_q - LEN_ONE;
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUT);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign last_beat = out_valid && ({1'b0, out_idx_q} == len_m1);
    assign cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_MAX);

    assign exp_x    = x_q;
    assign out_exp  = mem_q[out_idx_q];
    assign out_idx  = out_idx_q;
    assign out_last = last_beat;
    assign sum      = sum_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;

    // Clamp inputs to +/-10.0 so the exp unit never sees an out-of-range operand.
    always_comb begin
        x_sat = in_data;
        if ($signed(in_data) > SAT_HI) begin
            x_sat = SAT_HI;
        end else if ($signed(in_data) < SAT_LO) begin
            x_sat = SAT_LO;
        end
    end

    always_comb begin
        pos  = (exp_y[20:16] > 5'd16) ? 5'd16 : exp_y[20:16];
        term = {16'h0000, exp_y[15:0]} << pos;
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ld_cnt_d  = ld_cnt_q;
        x_d       = x_q;
        v_d       = 1'b0;
        wr_idx_d  = wr_idx_q;
        sum_d     = sum_q;
        out_idx_d = out_idx_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // The exp stage retires one staged operand per cycle, whatever the state.
        if (v_q) begin
            wr_idx_d = wr_idx_q + IDX_ONE;
            sum_d    = sum_q + SUM_W'(term);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        len_d     = cfg_len;
                        ld_cnt_d  = '0;
                        wr_idx_d  = '0;
                        sum_d     = '0;
                        out_idx_d = '0;
                        state_d   = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (in_hs) begin
                    x_d      = x_sat;
                    v_d      = 1'b1;
                    ld_cnt_d = ld_cnt_q + LEN_ONE;
                    if (ld_cnt_q == len_m1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                out_idx_d = '0;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (out_hs) begin
                    if (last_beat) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        out_idx_d = out_idx_q + IDX_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            ld_cnt_q  <= '0;
            x_q       <= '0;
            v_q       <= 1'b0;
            wr_idx_q  <= '0;
            sum_q     <= '0;
            out_idx_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ld_cnt_q  <= ld_cnt_d;
            x_q       <= x_d;
            v_q       <= v_d;
            wr_idx_q  <= wr_idx_d;
            sum_q     <= sum_d;
            out_idx_q <= out_idx_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Result buffer needs no reset; entries are always written before being read.
    always_ff @(posedge clk) begin
        if (v_q) begin
            mem_q[wr_idx_q] <= exp_y;
        end
    end

endmodule
